// File: rtl/bpred_pkg.sv
// Shared branch-prediction types and saturating arithmetic helpers.
// Used by the resolve queue and the bimodal predictor counters.
package bpred_pkg;

    localparam int BPRED_PC_W = 64;

    typedef struct packed {
        logic [BPRED_PC_W-1:0] pc;
        logic                  pred_taken;
        logic                  pred_known;
        logic                  valid;
    } brq_entry_t;

    function automatic logic [63:0] inc_sat(
        input logic [63:0] v,
        input logic [63:0] max
    );
        return (v >= max) ? max : v + 64'd1;
    endfunction

    function automatic logic [63:0] dec_sat(input logic [63:0] v);
        return (v == 64'd0) ? 64'd0 : v - 64'd1;
    endfunction

endpackage

// File: rtl/brq_sat_counter.sv
// Saturating up-counter for branch statistics.
module brq_sat_counter
    import bpred_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [63:0] MAX = 64'({CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= CNT_W'(inc_sat(64'(cnt), MAX));
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch tracking queue: forwards PCs to the predictor,
// captures predictions, and emits predictor updates on resolve.
module branch_resolve_queue
    import bpred_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_alloc_valid,
    input  logic [PC_W-1:0]  i_alloc_pc,
    output logic             o_alloc_ready,
    output logic             o_pred_valid,
    output logic [PC_W-1:0]  o_pred_pc,
    input  logic             i_pred_taken,
    input  logic             i_resolve_valid,
    input  logic             i_resolve_taken,
    output logic             o_resolve_ready,
    input  logic             i_flush,
    output logic             o_update_valid,
    output logic [PC_W-1:0]  o_update_pc,
    output logic             o_result_taken,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    brq_entry_t      entries [DEPTH];
    logic [IW-1:0]   head;
    logic [IW-1:0]   tail;
    logic [IW-1:0]   pend_idx;
    logic [CW-1:0]   count;
    logic            pend_valid;
    logic            alloc_fire;
    logic            res_fire;
    logic            head_pend;
    logic            eff_pred;
    logic            mispredict;

    assign o_alloc_ready   = (count != CW'(DEPTH));
    assign alloc_fire      = i_alloc_valid & o_alloc_ready & ~i_flush;
    assign o_pred_valid    = alloc_fire;
    assign o_pred_pc       = i_alloc_pc;

    // Head still waiting on its prediction: take it straight off the port.
    assign head_pend       = pend_valid & (pend_idx == head);
    assign eff_pred        = head_pend ? i_pred_taken
                                       : entries[head].pred_taken;
    assign o_resolve_ready = (count != '0) &
                             (entries[head].pred_known | head_pend);
    assign res_fire        = i_resolve_valid & o_resolve_ready & ~i_flush;
    assign mispredict      = i_resolve_taken != eff_pred;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            pend_valid     <= 1'b0;
            pend_idx       <= '0;
            o_update_valid <= 1'b0;
            o_update_pc    <= '0;
            o_result_taken <= 1'b0;
            o_mispredict   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            o_update_valid <= 1'b0;
            o_mispredict   <= 1'b0;
            if (i_flush) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                pend_valid <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].valid      <= 1'b0;
                    entries[i].pred_known <= 1'b0;
                end
            end else begin
                if (pend_valid) begin
                    entries[pend_idx].pred_taken <= i_pred_taken;
                    entries[pend_idx].pred_known <= 1'b1;
                end
                if (alloc_fire) begin
                    entries[tail] <= '{
                        pc:         BPRED_PC_W'(i_alloc_pc),
                        pred_taken: 1'b0,
                        pred_known: 1'b0,
                        valid:      1'b1
                    };
                    tail <= tail + 1'b1;
                end
                pend_valid <= alloc_fire;
                pend_idx   <= tail;
                if (res_fire) begin
                    head                 <= head + 1'b1;
                    entries[head].valid  <= 1'b0;
                    o_update_valid       <= 1'b1;
                    o_update_pc          <= PC_W'(entries[head].pc);
                    o_result_taken       <= i_resolve_taken;
                    o_mispredict         <= mispredict;
                end
                count <= count + CW'(alloc_fire) - CW'(res_fire);
            end
        end
    end

    brq_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .en    (res_fire),
        .cnt   (o_branch_cnt)
    );

    brq_sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .en    (res_fire & mispredict),
        .cnt   (o_mispred_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized bench for branch_resolve_queue against a queue-based model.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int PC_W  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alloc_valid = 1'b0;
    logic [PC_W-1:0]  alloc_pc = '0;
    logic             alloc_ready;
    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_taken = 1'b0;
    logic             resolve_valid = 1'b0;
    logic             resolve_taken = 1'b0;
    logic             resolve_ready;
    logic             flush = 1'b0;
    logic             update_valid;
    logic [PC_W-1:0]  update_pc;
    logic             result_taken;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    logic [PC_W-1:0] q[$];
    logic            exp_uv;
    logic [PC_W-1:0] exp_pc;
    logic            exp_rt;
    logic            exp_mis;
    int              exp_bcnt;
    int              exp_mcnt;

    branch_resolve_queue #(
        .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_alloc_valid   (alloc_valid),
        .i_alloc_pc      (alloc_pc),
        .o_alloc_ready   (alloc_ready),
        .o_pred_valid    (pred_valid),
        .o_pred_pc       (pred_pc),
        .i_pred_taken    (pred_taken),
        .i_resolve_valid (resolve_valid),
        .i_resolve_taken (resolve_taken),
        .o_resolve_ready (resolve_ready),
        .i_flush         (flush),
        .o_update_valid  (update_valid),
        .o_update_pc     (update_pc),
        .o_result_taken  (result_taken),
        .o_mispredict    (mispredict),
        .o_branch_cnt    (branch_cnt),
        .o_mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic pred_fn(input logic [PC_W-1:0] pc);
        return ~^pc[7:2];
    endfunction

    // Stand-in predictor: registered answer, junk when not asked.
    always @(posedge clk) begin
        pred_taken <= pred_valid ? pred_fn(pred_pc) : 1'($urandom);
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic model_clear();
        q.delete();
        exp_uv   = 1'b0;
        exp_pc   = '0;
        exp_rt   = 1'b0;
        exp_mis  = 1'b0;
        exp_bcnt = 0;
        exp_mcnt = 0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
        #1;
        model_clear();
        chk("rst_update_valid", 64'(update_valid), 0);
        chk("rst_update_pc", update_pc, 0);
        chk("rst_result_taken", 64'(result_taken), 0);
        chk("rst_mispredict", 64'(mispredict), 0);
        chk("rst_branch_cnt", 64'(branch_cnt), 0);
        chk("rst_mispred_cnt", 64'(mispred_cnt), 0);
        chk("rst_alloc_ready", 64'(alloc_ready), 1);
        chk("rst_resolve_ready", 64'(resolve_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle, entered and left at a negedge.
    task automatic cycle(input logic av, input logic [PC_W-1:0] pc,
                         input logic rv, input logic rt,
                         input logic fl);
        logic afire;
        logic rfire;
        logic [PC_W-1:0] e;
        alloc_valid   = av;
        alloc_pc      = pc;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        #1;
        afire = av && (q.size() < DEPTH) && !fl;
        rfire = rv && (q.size() != 0) && !fl;
        chk("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
        chk("resolve_ready", 64'(resolve_ready), 64'(q.size() != 0));
        chk("pred_valid", 64'(pred_valid), 64'(afire));
        exp_uv  = 1'b0;
        exp_mis = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (rfire) begin
                e       = q.pop_front();
                exp_uv  = 1'b1;
                exp_pc  = e;
                exp_rt  = rt;
                exp_mis = (rt != pred_fn(e));
                exp_bcnt = sat(exp_bcnt);
                if (exp_mis) exp_mcnt = sat(exp_mcnt);
            end
            if (afire) q.push_back(pc);
        end
        @(posedge clk);
        @(negedge clk);
        chk("update_valid", 64'(update_valid), 64'(exp_uv));
        chk("update_pc", update_pc, exp_pc);
        chk("result_taken", 64'(result_taken), 64'(exp_rt));
        chk("mispredict", 64'(mispredict), 64'(exp_mis));
        chk("branch_cnt", 64'(branch_cnt), 64'(exp_bcnt));
        chk("mispred_cnt", 64'(mispred_cnt), 64'(exp_mcnt));
    endtask

    function automatic logic [PC_W-1:0] rnd_pc();
        return {$urandom, $urandom} & ~64'h3;
    endfunction

    initial begin
        int pa;
        int pr;
        logic [PC_W-1:0] p;
        repeat (2) @(negedge clk);
        do_reset();

        cycle(1, 64'h1000, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);

        cycle(1, 64'h1000, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);

        for (int i = 0; i < 9; i++) cycle(1, 64'(i * 4), 0, 0, 0);
        cycle(1, 64'h40, 1, 1, 0);
        for (int i = 0; i < 3 * DEPTH; i++)
            cycle(1, 64'(i * 4 + 'h100), 1, 1'($urandom), 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1'($urandom), 0);

        for (int i = 0; i < 3; i++) cycle(1, rnd_pc(), 0, 0, 0);
        cycle(1, 64'h2000, 1, 1, 1);
        cycle(0, 0, 1, 1, 0);
        cycle(1, 64'h3000, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            p = rnd_pc();
            cycle(1, p, 0, 0, 0);
            cycle(0, 0, 1, ~pred_fn(p), 0);
        end

        for (int ph = 0; ph < 6; ph++) begin
            pa = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 30 : 60;
            pr = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 85 : 60;
            for (int i = 0; i < 250; i++) begin
                cycle(1'($urandom_range(0, 99) < pa), rnd_pc(),
                      1'($urandom_range(0, 99) < pr), 1'($urandom),
                      1'($urandom_range(0, 99) < 3));
            end
            for (int i = 0; i < 4; i++) cycle(1, rnd_pc(), 0, 0, 0);
            do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order tracking queue between the fetch-side branch source and the bimodal `predictor`.
- Forwards each branch PC to the predictor's predict port and captures the registered prediction one cycle later.
- Holds each branch until its outcome resolves, then drives the predictor's update port with the PC and outcome.
- Flags mispredicts and keeps branch and mispredict statistics.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- PC_W, 64, PC width; must match the predictor PC width.
- CNT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_alloc_valid  in  1  new branch presented this cycle.
- i_alloc_pc  in  PC_W  PC of the new branch.
- o_alloc_ready  out  1  queue can accept (not full).
- o_pred_valid  out  1  to predictor i_pred_valid.
- o_pred_pc  out  PC_W  to predictor i_pred_pc.
- i_pred_taken  in  1  from predictor o_pred_taken (registered, 1-cycle latency).
- i_resolve_valid  in  1  outcome of the oldest branch.
- i_resolve_taken  in  1  actual direction.
- o_resolve_ready  out  1  head entry can be resolved this cycle.
- i_flush  in  1  synchronous queue clear.
- o_update_valid  out  1  to predictor i_update_valid.
- o_update_pc  out  PC_W  to predictor i_update_pc.
- o_result_taken  out  1  to predictor i_result_taken.
- o_mispredict  out  1  1-cycle pulse, aligned with o_update_valid.
- o_branch_cnt  out  CNT_W  resolved-branch count.
- o_mispred_cnt  out  CNT_W  mispredict count.

Behaviour:
- Reset (async, active-low) clears:
  - head, tail, count, pending-capture flag, all entry valid/known bits;
  - o_update_valid, o_update_pc, o_result_taken, o_mispredict, both counters → 0.
  - After reset, o_alloc_ready=1 and o_resolve_ready=0.
- Entry fields: pc[PC_W], pred_taken, pred_known.
- Allocation accepted when alloc_fire = i_alloc_valid & o_alloc_ready & !i_flush.
  - o_alloc_ready = (count != DEPTH); it depends only on registered state, never on same-cycle resolve.
- o_pred_valid = alloc_fire (combinational); o_pred_pc = i_alloc_pc.
- On alloc_fire:
  - entry[tail] ← {i_alloc_pc, 0, known=0};
  - tail advances modulo DEPTH;
  - pend_valid ← 1, pend_idx ← old tail.
  - Otherwise pend_valid ← 0.
- Prediction capture: when pend_valid, entry[pend_idx].pred_taken ← i_pred_taken and known ← 1.
- o_resolve_ready = (count != 0) & (entry[head].known | (pend_valid & pend_idx==head)).
  - The second term is a bypass: the effective prediction is i_pred_taken when the head is the pending entry.
- Resolve accepted when res_fire = i_resolve_valid & o_resolve_ready & !i_flush.
  - i_resolve_valid while not ready is ignored; no error.
- On res_fire:
  - head advances modulo DEPTH;
  - o_update_valid ← 1, o_update_pc ← entry[head].pc, o_result_taken ← i_resolve_taken;
  - o_mispredict ← (i_resolve_taken != effective prediction).
  - Otherwise o_update_valid and o_mispredict ← 0; o_update_pc and o_result_taken hold.
  - Latency: resolve to update is 1 cycle.
- count ← count + alloc_fire − res_fire.
  - Simultaneous alloc and resolve leaves count unchanged.
  - count width is $clog2(DEPTH)+1.
- Counters:
  - branch_cnt += res_fire; mispred_cnt += res_fire & mispredict.
  - Both saturate at all-ones and do not wrap.
- Flush (i_flush=1):
  - next cycle head=tail=count=0, pend_valid=0, all entries invalid;
  - same-cycle alloc and resolve are dropped; o_pred_valid=0 that cycle; o_update_valid=0 next cycle.
  - Counters are not cleared.
  - A prediction arriving the cycle after a flush is discarded (pend_valid already 0).
- Full: allocation refused, i_alloc_valid ignored, upstream must hold. Empty: o_resolve_ready=0.
- Reset mid-operation: all in-flight entries are lost; no update is emitted.

Decomposition:
- Package bpred_pkg holds:
  - typedef brq_entry_t {pc, pred_taken, pred_known, valid};
  - default PC_W;
  - inc_sat/dec_sat helper functions, shared with the predictor's counter logic.
- One sub-module, brq_sat_counter (CNT_W, increment enable, saturating), instantiated twice for the statistics.
- The queue itself is flat.

Test Plan:
- Reset, then alloc PC 0x1000, predictor returns taken, resolve taken → o_update_valid 1 cycle after resolve, o_update_pc=0x1000, o_result_taken=1, o_mispredict=0, branch_cnt=1.
- Alloc at cycle N, resolve not-taken at N+1 while the prediction (taken) is still pending → bypass gives o_resolve_ready=1; update at N+2 with o_mispredict=1, mispred_cnt=1.
- Fill 8 entries (PCs 0x0..0x1C step 4), assert 9th alloc → o_alloc_ready=0 and 9th dropped; resolve all 8 in order → update PCs 0x0..0x1C in order; afterwards o_resolve_ready=0.
- Full queue with simultaneous alloc+resolve → alloc refused that cycle, count=7 next cycle, head/tail wrap correctly over 3 laps of traffic.
- Three entries queued, assert i_flush with alloc and resolve high → no o_pred_valid, no update, count=0, counters unchanged; a late i_pred_taken is ignored.
- Force mispred_cnt to all-ones via 2^CNT_W-1 mispredicts (use CNT_W=4 build) → stays at 15; reset mid-queue → all outputs 0, o_alloc_ready=1.
